jtbubl_rom_arb: RTL
===================

JTBUBL_ROM_ARB -- requirements
Module: jtbubl_rom_arb

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning):
  MAIN_OFFSET  22'h00000  main slot base, 16-bit SDRAM words
  SUB_OFFSET   22'h14000  sub slot base
  SND_OFFSET   22'h18000  sound slot base
  GFX_OFFSET   22'h20000  gfx slot base
  GFX_STREAK   2          max consecutive gfx grants while a CPU slot waits
REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
  clk  in 1  system clock, sole clock; rst  in 1  synchronous active-high reset
  downloading  in 1  ROM load in progress; loop_rst  in 1  invalidate and restart
  main_cs/main_addr/main_ok/main_dout  in1/in18/out1/out8  main CPU ROM slot
  sub_cs/sub_addr/sub_ok/sub_dout  in1/in15/out1/out8  sub CPU ROM slot
  snd_cs/snd_addr/snd_ok/snd_dout  in1/in15/out1/out8  sound ROM slot
  gfx_cs/gfx_addr/gfx_ok/gfx_dout  in1/in18/out1/out32  graphics ROM slot
  sdram_req  out 1  read request; sdram_ack  in 1  request accepted
  sdram_addr  out 22  word address; data_read  in 32  read data; data_rdy  in 1  data valid
  refresh_en  out 1  SDRAM refresh allowed

Function
REQ-003 Each slot SHALL hold a one-entry cache: 32-bit data, tag, valid bit.
REQ-004 8-bit slots: tag = addr[AW-1:2]; sdram_addr = OFFSET + {addr[AW-1:2],1'b0}; dout = data[8*addr[1:0] +: 8].
REQ-005 gfx slot: tag = gfx_addr; sdram_addr = GFX_OFFSET + {gfx_addr,1'b0}; dout = full 32-bit word.
REQ-006 x_ok SHALL be combinational: cs & valid & (tag == current addr tag); a hit has zero-cycle latency; address change drops ok the same cycle.
REQ-007 x_dout SHALL be combinational from cache; value undefined-but-stable when ok=0.
REQ-008 FSM states: IDLE, WAIT_ACK, WAIT_RDY.
REQ-009 IDLE: if any slot has cs & miss and downloading=0, latch winner id, its tag and sdram_addr; assert sdram_req next cycle; go WAIT_ACK.
REQ-010 WAIT_ACK: hold sdram_req=1 and sdram_addr stable until sdram_ack; on sdram_ack deassert sdram_req next cycle; go WAIT_RDY.
REQ-011 WAIT_RDY: on data_rdy write data_read and latched tag into winner cache, set valid; go IDLE; next grant earliest the following cycle.
REQ-012 Arbitration: gfx highest priority; main, sub, snd round-robin (pointer advances past last CPU winner).
REQ-013 Once gfx has won GFX_STREAK consecutive grants while any CPU slot misses, the next grant SHALL go to a CPU slot.
REQ-014 Requester address change during WAIT_ACK/WAIT_RDY SHALL NOT abort the fetch; the latched tag is stored, then a new miss re-arbitrates.
REQ-015 cs dropped mid-fetch: fetch completes and fills cache normally.
REQ-016 data_rdy outside WAIT_RDY and sdram_ack outside WAIT_ACK SHALL be ignored.
REQ-017 downloading=1: clear all valid bits, sdram_req=0, FSM forced IDLE, all ok=0.
REQ-018 loop_rst=1: same effect as REQ-017 for that cycle.
REQ-019 refresh_en SHALL be 1 in IDLE when no slot has cs & miss, else 0.

Reset
REQ-020 rst SHALL force: FSM IDLE, sdram_req=0, sdram_addr=0, all valid=0, all ok=0, round-robin pointer=main, gfx streak counter=0, refresh_en=1.
REQ-021 rst asserted mid-fetch SHALL abandon the fetch; a later data_rdy SHALL write nothing.

Structure
REQ-022 Package jtbubl_rom_pkg SHALL hold FSM state encoding, slot id encoding (MAIN=0, SUB=1, SND=2, GFX=3) and slot count.
REQ-023 Sub-module jtbubl_rom_slot SHALL implement one cache entry (tag compare, ok, byte select), parameterized by AW and DW, instantiated four times.

Verification
REQ-024 main_cs=1, main_addr=18'h00005, ack 2 cycles later, data_rdy with 32'hDDCCBBAA -> sdram_addr=22'h00002, main_ok=1, main_dout=8'hBB; main_addr=18'h00006 -> ok same cycle, dout=8'hCC, no new sdram_req.
REQ-025 gfx and sub miss together -> gfx served first, sub second; gfx misses continuously with snd waiting, GFX_STREAK=2 -> grant order gfx, gfx, snd.
REQ-026 main, sub, snd all miss repeatedly -> grant order main, sub, snd, main.
REQ-027 sub_addr changes during WAIT_RDY -> cache filled with old tag, sub_ok=0, new request issued next IDLE.
REQ-028 rst pulse in WAIT_RDY then data_rdy -> no ok asserted, sdram_req=0, refresh_en=1.
REQ-029 downloading=1 with valid caches -> all ok=0 immediately, no sdram_req; after downloading=0 refetch on demand.

Source files
------------

// File: rtl/jtbubl_rom_pkg.sv
// jtbubl_rom_pkg: shared encodings for the ROM arbiter and its slot caches
package jtbubl_rom_pkg;
  localparam int SLOTS = 4;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
  typedef enum logic [1:0] {MAIN = 2'd0, SUB = 2'd1, SND = 2'd2, GFX = 2'd3} slot_t;
endpackage

// File: rtl/jtbubl_rom_arb_if.sv
// jtbubl_rom_arb_if: requester slots and SDRAM read port of the ROM arbiter
interface jtbubl_rom_arb_if;
  logic        main_cs;
  logic [17:0] main_addr;
  logic        main_ok;
  logic [7:0]  main_dout;
  logic        sub_cs;
  logic [14:0] sub_addr;
  logic        sub_ok;
  logic [7:0]  sub_dout;
  logic        snd_cs;
  logic [14:0] snd_addr;
  logic        snd_ok;
  logic [7:0]  snd_dout;
  logic        gfx_cs;
  logic [17:0] gfx_addr;
  logic        gfx_ok;
  logic [31:0] gfx_dout;
  logic        sdram_req;
  logic        sdram_ack;
  logic [21:0] sdram_addr;
  logic [31:0] data_read;
  logic        data_rdy;
  logic        refresh_en;
  modport slave (
    input  main_cs, main_addr, sub_cs, sub_addr, snd_cs, snd_addr, gfx_cs, gfx_addr,
    output main_ok, main_dout, sub_ok, sub_dout, snd_ok, snd_dout, gfx_ok, gfx_dout,
    output sdram_req, sdram_addr, refresh_en,
    input  sdram_ack, data_read, data_rdy
  );
  modport master (
    output main_cs, main_addr, sub_cs, sub_addr, snd_cs, snd_addr, gfx_cs, gfx_addr,
    input  main_ok, main_dout, sub_ok, sub_dout, snd_ok, snd_dout, gfx_ok, gfx_dout,
    input  sdram_req, sdram_addr, refresh_en,
    output sdram_ack, data_read, data_rdy
  );
endinterface

// File: rtl/jtbubl_rom_slot.sv
// jtbubl_rom_slot: one-entry 32-bit read cache with tag compare and byte select
module jtbubl_rom_slot #(
  parameter  int AW = 18,
  parameter  int DW = 8,
  localparam int TW = DW == 32 ? AW : AW - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          ok,
  output logic          miss,
  output logic [TW-1:0] tag,
  output logic [DW-1:0] dout
);
  logic [31:0]   data;
  logic [TW-1:0] tag_q;
  logic          valid;
  logic          hit;

  assign tag  = addr[AW-1 -: TW];
  assign hit  = valid & (tag_q == tag);
  assign ok   = cs & hit & ~(rst | clr);
  assign miss = cs & ~hit;

  generate
    if (DW == 32) begin : g_word
      assign dout = data[DW-1:0];
    end else begin : g_byte
      assign dout = data[{addr[1:0], 3'b0} +: DW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) valid <= 1'b0;
    else if (wr) valid <= 1'b1;
    if (wr) begin
      data  <= wr_data;
      tag_q <= wr_tag;
    end
  end
endmodule

// File: rtl/jtbubl_rom_arb.sv
// jtbubl_rom_arb: four cached ROM slots sharing one SDRAM read port
module jtbubl_rom_arb
  import jtbubl_rom_pkg::*;
#(
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] SUB_OFFSET  = 22'h14000,
  parameter logic [21:0] SND_OFFSET  = 22'h18000,
  parameter logic [21:0] GFX_OFFSET  = 22'h20000,
  parameter int          GFX_STREAK  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            downloading,
  input  logic            loop_rst,
  jtbubl_rom_arb_if.slave bus
);
  logic             clr, grant, cpu_any, gfx_go;
  logic [SLOTS-1:0] miss, fill;
  logic [15:0]      main_tag;
  logic [12:0]      sub_tag, snd_tag;
  logic [17:0]      gfx_tag, win_tag, pick_tag;
  logic [21:0]      pick_addr;
  logic [1:0]       rr, rr1, rr2, cpu_pick;
  logic [7:0]       streak;
  state_t           state, nxt;
  slot_t            win, pick;

  assign clr = downloading | loop_rst;

  jtbubl_rom_slot #(.AW(18), .DW(8)) u_main (
    .clk, .rst, .clr, .cs(bus.main_cs), .addr(bus.main_addr), .wr(fill[MAIN]),
    .wr_tag(win_tag[15:0]), .wr_data(bus.data_read), .ok(bus.main_ok),
    .miss(miss[MAIN]), .tag(main_tag), .dout(bus.main_dout)
  );
  jtbubl_rom_slot #(.AW(15), .DW(8)) u_sub (
    .clk, .rst, .clr, .cs(bus.sub_cs), .addr(bus.sub_addr), .wr(fill[SUB]),
    .wr_tag(win_tag[12:0]), .wr_data(bus.data_read), .ok(bus.sub_ok),
    .miss(miss[SUB]), .tag(sub_tag), .dout(bus.sub_dout)
  );
  jtbubl_rom_slot #(.AW(15), .DW(8)) u_snd (
    .clk, .rst, .clr, .cs(bus.snd_cs), .addr(bus.snd_addr), .wr(fill[SND]),
    .wr_tag(win_tag[12:0]), .wr_data(bus.data_read), .ok(bus.snd_ok),
    .miss(miss[SND]), .tag(snd_tag), .dout(bus.snd_dout)
  );
  jtbubl_rom_slot #(.AW(18), .DW(32)) u_gfx (
    .clk, .rst, .clr, .cs(bus.gfx_cs), .addr(bus.gfx_addr), .wr(fill[GFX]),
    .wr_tag(win_tag), .wr_data(bus.data_read), .ok(bus.gfx_ok),
    .miss(miss[GFX]), .tag(gfx_tag), .dout(bus.gfx_dout)
  );

  // gfx wins unless it has already taken GFX_STREAK grants in a row over a waiting CPU
  always_comb begin
    cpu_any   = |miss[2:0];
    rr1       = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    rr2       = rr == 2'd0 ? 2'd2 : rr - 2'd1;
    cpu_pick  = miss[rr] ? rr : miss[rr1] ? rr1 : rr2;
    gfx_go    = miss[GFX] & ~(cpu_any & (int'(streak) >= GFX_STREAK));
    pick      = gfx_go ? GFX : slot_t'(cpu_pick);
    pick_tag  = pick == GFX ? gfx_tag : pick == SND ? 18'(snd_tag) :
                pick == SUB ? 18'(sub_tag) : 18'(main_tag);
    pick_addr = pick == GFX ? GFX_OFFSET + 22'({gfx_tag, 1'b0}) :
                pick == SND ? SND_OFFSET + 22'({snd_tag, 1'b0}) :
                pick == SUB ? SUB_OFFSET + 22'({sub_tag, 1'b0}) :
                              MAIN_OFFSET + 22'({main_tag, 1'b0});
    grant     = (state == IDLE) & |miss & ~clr;
    nxt       = state;
    nxt       = clr ? IDLE :
                state == IDLE     ? (grant ? WAIT_ACK : IDLE) :
                state == WAIT_ACK ? (bus.sdram_ack ? WAIT_RDY : WAIT_ACK) :
                                    (bus.data_rdy ? IDLE : WAIT_RDY);
    fill      = (state == WAIT_RDY) & bus.data_rdy & ~clr ? SLOTS'(1) << win : '0;
  end

  assign bus.sdram_req  = state == WAIT_ACK;
  assign bus.refresh_en = rst | ((state == IDLE) & ~|miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      win            <= MAIN;
      win_tag        <= '0;
      bus.sdram_addr <= '0;
      rr             <= 2'd0;
      streak         <= '0;
    end else begin
      state <= nxt;
      if (grant) begin
        win            <= pick;
        win_tag        <= pick_tag;
        bus.sdram_addr <= pick_addr;
        streak         <= gfx_go & cpu_any ? streak + 8'd1 : '0;
        if (!gfx_go) rr <= cpu_pick == 2'd2 ? 2'd0 : cpu_pick + 2'd1;
      end
    end
  end
endmodule
